// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared types and constants for the RISC core fetch stage
package risc_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int             OPCODE_WIDTH        = 4;
    localparam logic [3:0]     HALT_OPCODE         = 4'hF;
    localparam int             DEFAULT_ADDR_WIDTH  = 16;
    localparam int             DEFAULT_INSTR_WIDTH = 32;

endpackage

// File: rtl/instruction_fetch_if.sv
// rtl/instruction_fetch_if.sv - IF/ID valid/ready handshake between fetch and decode
interface instruction_fetch_if
    import risc_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int INSTR_WIDTH = DEFAULT_INSTR_WIDTH
) ();

    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0]  out_pc;

    modport master (
        output out_valid,
        output out_instr,
        output out_pc,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_instr,
        input  out_pc,
        output out_ready
    );

endinterface

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - program counter, IF/ID register and fetch FSM
module instruction_fetch
    import risc_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
    parameter int                    INSTR_WIDTH = DEFAULT_INSTR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    PC_STEP     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic [INSTR_WIDTH-1:0] imem_data,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   halted,
    instruction_fetch_if.master    dec
);

    fetch_state_t            state, state_next;
    logic [ADDR_WIDTH-1:0]   pc, pc_next;
    logic                    valid_next;
    logic [INSTR_WIDTH-1:0]  instr_next;
    logic [ADDR_WIDTH-1:0]   out_pc_next;
    logic                    load;
    logic [OPCODE_WIDTH-1:0] opcode;

    assign imem_addr = pc;
    assign halted    = (state == HALTED);
    assign opcode    = imem_data[INSTR_WIDTH-1 -: OPCODE_WIDTH];
    // out_ready only gates register updates, never out_valid directly
    assign load      = (state == RUN) && !redirect_valid && (!dec.out_valid || dec.out_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            dec.out_valid <= 1'b0;
            dec.out_instr <= '0;
            dec.out_pc    <= '0;
        end else begin
            state         <= state_next;
            pc            <= pc_next;
            dec.out_valid <= valid_next;
            dec.out_instr <= instr_next;
            dec.out_pc    <= out_pc_next;
        end
    end

    always_comb begin
        state_next  = state;
        pc_next     = pc;
        valid_next  = dec.out_valid;
        instr_next  = dec.out_instr;
        out_pc_next = dec.out_pc;

        if (dec.out_valid && dec.out_ready) begin
            valid_next = 1'b0;
        end

        if (redirect_valid) begin
            // Flush whatever is held; first fetch from the target happens next cycle
            pc_next    = redirect_pc;
            valid_next = 1'b0;
            state_next = RUN;
        end else begin
            case (state)
                BOOT: state_next = RUN;
                RUN: begin
                    if (load) begin
                        instr_next  = imem_data;
                        out_pc_next = pc;
                        valid_next  = 1'b1;
                        if (opcode == HALT_OPCODE) begin
                            state_next = HALTED;
                        end else begin
                            pc_next = pc + ADDR_WIDTH'(PC_STEP);
                        end
                    end
                end
                HALTED:  state_next = HALTED;
                default: state_next = BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for the fetch stage
module tb_instruction_fetch;
    import risc_pkg::*;

    typedef struct {
        logic [15:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [15:0] imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        halted;
    logic        halt_en;

    int   tests_run;
    int   tests_failed;
    exp_t exp_q[$];

    instruction_fetch_if #(.ADDR_WIDTH(16), .INSTR_WIDTH(32)) dec_if ();

    instruction_fetch #(
        .ADDR_WIDTH (16),
        .INSTR_WIDTH(32),
        .RESET_PC   (16'h0000),
        .PC_STEP    (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .halted        (halted),
        .dec           (dec_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_data = (halt_en && imem_addr == 16'd5) ? 32'hF000_0000
                                                      : (32'h1000_0000 | {16'h0000, imem_addr});

    function automatic logic [31:0] word_at(input logic [15:0] a, input logic hen);
        if (hen && a == 16'd5) return 32'hF000_0000;
        return 32'h1000_0000 | {16'h0000, a};
    endfunction

    task automatic push_exp(input logic [15:0] a);
        exp_t e;
        e.pc    = a;
        e.instr = word_at(a, halt_en);
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every accepted transfer must match the next scoreboard entry in order
    always @(negedge clk) begin
        if (!rst && dec_if.out_valid && dec_if.out_ready) begin
            exp_t e;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL xfer_unexpected: got pc=%h instr=%h, expected no transfer",
                         dec_if.out_pc, dec_if.out_instr);
            end else begin
                e = exp_q.pop_front();
                if (dec_if.out_pc !== e.pc || dec_if.out_instr !== e.instr) begin
                    tests_failed++;
                    $display("FAIL xfer_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                             dec_if.out_pc, dec_if.out_instr, e.pc, e.instr);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; dec_if.out_ready = 1'b1; redirect_valid = 1'b0;
        redirect_pc = '0; halt_en = 1'b0;
        tick(); tick();
        tests_run++;
        if (dec_if.out_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 16'h0000 ||
            dec_if.out_pc !== 16'h0000 || dec_if.out_instr !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_state: valid=%b halted=%b addr=%h pc=%h instr=%h, expected all zero",
                     dec_if.out_valid, halted, imem_addr, dec_if.out_pc, dec_if.out_instr);
        end
        rst = 1'b0;
        tick();
        tests_run++;
        if (dec_if.out_valid !== 1'b0 || imem_addr !== 16'h0000) begin
            tests_failed++;
            $display("FAIL boot_no_fetch: valid=%b addr=%h, expected 0 0000", dec_if.out_valid, imem_addr);
        end
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) push_exp(16'(i));
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 16'(i) ||
                dec_if.out_instr !== word_at(16'(i), 1'b0) || imem_addr !== 16'(i + 1)) begin
                tests_failed++;
                $display("FAIL stream_%0d: valid=%b pc=%h instr=%h addr=%h, expected 1 %h %h %h", i,
                         dec_if.out_valid, dec_if.out_pc, dec_if.out_instr, imem_addr,
                         16'(i), word_at(16'(i), 1'b0), 16'(i + 1));
            end
        end
    endtask

    task automatic test_backpressure();
        dec_if.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 16'd2 ||
                dec_if.out_instr !== 32'h1000_0002 || imem_addr !== 16'd3) begin
                tests_failed++;
                $display("FAIL stall_%0d: valid=%b pc=%h instr=%h addr=%h, expected 1 0002 10000002 0003",
                         i, dec_if.out_valid, dec_if.out_pc, dec_if.out_instr, imem_addr);
            end
        end
        dec_if.out_ready = 1'b1;
        tick();
        tests_run++;
        if (dec_if.out_pc !== 16'd3 || imem_addr !== 16'd4) begin
            tests_failed++;
            $display("FAIL stall_resume: pc=%h addr=%h, expected 0003 0004", dec_if.out_pc, imem_addr);
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect_valid = 1'b0;
        tests_run++;
        if (dec_if.out_valid !== 1'b0 || imem_addr !== 16'h0040) begin
            tests_failed++;
            $display("FAIL redirect_flush: valid=%b addr=%h, expected 0 0040", dec_if.out_valid, imem_addr);
        end
        push_exp(16'h0040); push_exp(16'h0041);
        tick();
        tests_run++;
        if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 16'h0040) begin
            tests_failed++;
            $display("FAIL redirect_target: valid=%b pc=%h, expected 1 0040", dec_if.out_valid, dec_if.out_pc);
        end
        tick();
        tests_run++;
        if (dec_if.out_pc !== 16'h0041 || imem_addr !== 16'h0042) begin
            tests_failed++;
            $display("FAIL redirect_next: pc=%h addr=%h, expected 0041 0042", dec_if.out_pc, imem_addr);
        end
    endtask

    task automatic test_halt();
        halt_en = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 16'h0003;
        tick();
        redirect_valid = 1'b0;
        push_exp(16'd3); push_exp(16'd4); push_exp(16'd5);
        tick(); tick(); tick();
        tests_run++;
        if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 16'd5 || dec_if.out_instr !== 32'hF000_0000 ||
            halted !== 1'b1 || imem_addr !== 16'd5) begin
            tests_failed++;
            $display("FAIL halt_deliver: valid=%b pc=%h instr=%h halted=%b addr=%h, expected 1 0005 f0000000 1 0005",
                     dec_if.out_valid, dec_if.out_pc, dec_if.out_instr, halted, imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (dec_if.out_valid !== 1'b0 || halted !== 1'b1 || imem_addr !== 16'd5) begin
                tests_failed++;
                $display("FAIL halt_hold_%0d: valid=%b halted=%b addr=%h, expected 0 1 0005",
                         i, dec_if.out_valid, halted, imem_addr);
            end
        end
        redirect_valid = 1'b1; redirect_pc = 16'h0010;
        tick();
        redirect_valid = 1'b0;
        halt_en = 1'b0;
        tests_run++;
        if (halted !== 1'b0 || dec_if.out_valid !== 1'b0 || imem_addr !== 16'h0010) begin
            tests_failed++;
            $display("FAIL halt_exit: halted=%b valid=%b addr=%h, expected 0 0 0010",
                     halted, dec_if.out_valid, imem_addr);
        end
        push_exp(16'h0010);
        tick();
        tests_run++;
        if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 16'h0010) begin
            tests_failed++;
            $display("FAIL halt_resume: valid=%b pc=%h, expected 1 0010", dec_if.out_valid, dec_if.out_pc);
        end
    endtask

    task automatic test_wrap();
        redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
        tick();
        redirect_valid = 1'b0;
        push_exp(16'hFFFE); push_exp(16'hFFFF); push_exp(16'h0000); push_exp(16'h0001);
        for (int i = 0; i < 4; i++) begin
            logic [15:0] want;
            want = 16'hFFFE + 16'(i);
            tick();
            tests_run++;
            if (dec_if.out_pc !== want || imem_addr !== want + 16'd1) begin
                tests_failed++;
                $display("FAIL wrap_%0d: pc=%h addr=%h, expected %h %h", i, dec_if.out_pc, imem_addr,
                         want, want + 16'd1);
            end
        end
    endtask

    task automatic test_reset_mid();
        dec_if.out_ready = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.delete();
        tick();
        tests_run++;
        if (dec_if.out_valid !== 1'b0 || halted !== 1'b0 || imem_addr !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_mid: valid=%b halted=%b addr=%h, expected 0 0 0000",
                     dec_if.out_valid, halted, imem_addr);
        end
        rst = 1'b0; dec_if.out_ready = 1'b1;
        tick();
        tests_run++;
        if (dec_if.out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_boot: valid=%b, expected 0", dec_if.out_valid);
        end
        push_exp(16'h0000);
        tick();
        dec_if.out_ready = 1'b0;
        tests_run++;
        if (dec_if.out_valid !== 1'b1 || dec_if.out_pc !== 16'h0000 || exp_q.size() != 1) begin
            tests_failed++;
            $display("FAIL reset_mid_refetch: valid=%b pc=%h pending=%0d, expected 1 0000 1",
                     dec_if.out_valid, dec_if.out_pc, exp_q.size());
        end
        tick();
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
